shifter_feeder: RTL and testbench

SHIFTER_FEEDER -- requirements
Module: shifter_feeder

---
 rtl/shifter_feeder.sv | 168 ++++++++++++++++
 tb/tb_shifter_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shifter_feeder.sv
// rtl/shifter_feeder.sv - word FIFO that feeds a shifter one word per empty/busy handshake
//
// Purpose: buffers producer words in a DEPTH-deep FIFO and loads them one at a
// time into a downstream shifter. A word is loaded (write pulse + data) when the
// shifter reports empty, then the feeder waits until the shifter goes busy
// before it is allowed to load the next word.
//
// Optional feature: define SHIFTER_FEEDER_TIMEOUT_EN to add a handshake timeout.
// If the shifter never leaves empty within TIMEOUT edges after a load, stall is
// set, the word is considered delivered and the feeder returns to IDLE.
// Without the macro the feeder waits indefinitely and stall is tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   push         in   producer offers push_data this cycle
//   push_data    in   WIDTH-bit word to enqueue
//   full         out  FIFO holds DEPTH words
//   level        out  number of stored words
//   overflow     out  sticky, a push was dropped
//   shift_empty  in   shifter empty flag
//   write        out  one-cycle load strobe to the shifter
//   data         out  last loaded word
//   stall        out  sticky, handshake timeout occurred

module shifter_feeder #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     shift_empty,
  output logic                     write,
  output logic [WIDTH-1:0]         data,
  output logic                     stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
    $error("shifter_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  typedef enum logic {IDLE, WAIT_BUSY} state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             overflow_q;
  logic             write_q;
  logic [WIDTH-1:0] data_q;
  state_t           state_q, state_d;
  logic             push_ok;
  logic             pop;

  // Fullness is judged before any same-edge pop, so a push into a full FIFO
  // is dropped even while a word is leaving.
  assign full    = (level_q == LW'(DEPTH));
  assign push_ok = push && !full;

`ifdef SHIFTER_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
`ifdef SHIFTER_FEEDER_TIMEOUT_EN
    stall_d = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (level_q != '0 && shift_empty) begin
          pop     = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!shift_empty) begin
          state_d = IDLE;
        end
`ifdef SHIFTER_FEEDER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // TIMEOUT-th edge spent waiting: give up on the handshake.
          stall_d = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef SHIFTER_FEEDER_TIMEOUT_EN
    // Counts edges spent in WAIT_BUSY; restarts on every entry.
    cnt_d = (state_q == WAIT_BUSY && state_d == WAIT_BUSY) ? cnt_q + CW'(1) : '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      write_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      write_q <= pop;
      if (pop) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (push && full) begin
        overflow_q <= 1'b1;
      end
      if (push_ok && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push_ok) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

`ifdef SHIFTER_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end
  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  assign level    = level_q;
  assign overflow = overflow_q;
  assign write    = write_q;
  assign data     = data_q;

endmodule

// File: tb/tb_shifter_feeder.sv
// tb/tb_shifter_feeder.sv - self-checking bench for shifter_feeder against a queue-based reference model

module tb_shifter_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [11:0] push_data;
  logic        full;
  logic [2:0]  level;
  logic        overflow;
  logic        shift_empty;
  logic        write;
  logic [11:0] data;
  logic        stall;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;

  logic [11:0] mq[$];
  logic        m_wait, m_ovf, m_stall, m_write;
  logic [11:0] m_data;
  int          m_cnt;

  shifter_feeder #(.WIDTH(12), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_data),
    .full        (full),
    .level       (level),
    .overflow    (overflow),
    .shift_empty (shift_empty),
    .write       (write),
    .data        (data),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_wait  = 1'b0;
    m_ovf   = 1'b0;
    m_stall = 1'b0;
    m_write = 1'b0;
    m_data  = '0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input logic p, input logic [11:0] pd, input logic se);
    bit was_full;
    was_full = (mq.size() == DEPTH);
    m_write  = 1'b0;
    if (m_wait) begin
      if (!se) m_wait = 1'b0;
`ifdef SHIFTER_FEEDER_TIMEOUT_EN
      else begin
        m_cnt++;
        if (m_cnt == TIMEOUT) begin
          m_stall = 1'b1;
          m_wait  = 1'b0;
        end
      end
`endif
    end else if (mq.size() > 0 && se) begin
      m_write = 1'b1;
      m_data  = mq.pop_front();
      m_wait  = 1'b1;
      m_cnt   = 0;
    end
    if (p) begin
      if (was_full) m_ovf = 1'b1;
      else          mq.push_back(pd);
    end
  endtask

  task automatic compare_all();
    chk("write",    {31'd0, write},    {31'd0, m_write});
    chk("data",     {20'd0, data},     {20'd0, m_data});
    chk("level",    {29'd0, level},    mq.size());
    chk("full",     {31'd0, full},     {31'd0, mq.size() == DEPTH});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("stall",    {31'd0, stall},    {31'd0, m_stall});
    if (write === 1'b1) wr_seen++;
  endtask

  // Called at a falling edge: drives inputs, lets one rising edge happen,
  // advances the model, and compares at the next falling edge.
  task automatic step(input logic p, input logic [11:0] pd, input logic se);
    push        = p;
    push_data   = pd;
    shift_empty = se;
    @(posedge clk);
    model_edge(p, pd, se);
    @(negedge clk);
    compare_all();
  endtask

  // Called at a falling edge: asserts reset asynchronously mid-cycle.
  task automatic apply_reset(input int hold);
    push = 1'b0;
    #2 reset = 1'b0;
    model_clear();
    #1 compare_all();
    repeat (hold) begin
      @(negedge clk);
      compare_all();
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int busy;
    logic se_v;
    reset       = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    shift_empty = 1'b1;
    model_clear();
    @(negedge clk);
    apply_reset(2);

    // Single word through an idle shifter.
    step(1'b1, 12'hC45, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    chk("single_write", {31'd0, write}, 32'd1);
    chk("single_data",  {20'd0, data},  32'hC45);
    chk("single_level", {29'd0, level}, 32'd0);

    // Burst fill while the shifter is busy; fifth push is dropped.
    apply_reset(1);
    for (int i = 1; i <= 5; i++) step(1'b1, 12'(i), 1'b0);
    chk("burst_level", {29'd0, level},    32'd4);
    chk("burst_full",  {31'd0, full},     32'd1);
    chk("burst_ovf",   {31'd0, overflow}, 32'd1);

    // Push into full FIFO on the same edge as a load: still dropped.
    step(1'b1, 12'h0FF, 1'b1);
    chk("simul_level", {29'd0, level},    32'd3);
    chk("simul_ovf",   {31'd0, overflow}, 32'd1);
    chk("simul_data",  {20'd0, data},     32'h001);

    // Handshake: shifter goes busy one cycle after each write, for 12 cycles.
    apply_reset(1);
    step(1'b1, 12'hA01, 1'b0);
    step(1'b1, 12'hA02, 1'b0);
    step(1'b1, 12'hA03, 1'b0);
    busy    = 0;
    wr_seen = 0;
    for (int i = 0; i < 60; i++) begin
      se_v = (busy == 0);
      if (busy > 0) busy--;
      step(1'b0, 12'h000, se_v);
      if (write === 1'b1) busy = 12;
    end
    chk("order_writes", wr_seen, 32'd3);

    // Reset while waiting for the shifter to go busy.
    apply_reset(1);
    step(1'b1, 12'h007, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    apply_reset(2);
    wr_seen = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 1'b1);
    chk("post_reset_writes", wr_seen, 32'd0);

    // Shifter never leaves empty after a load.
    apply_reset(1);
    step(1'b1, 12'h111, 1'b0);
    step(1'b1, 12'h222, 1'b0);
    wr_seen = 0;
    for (int i = 0; i < 80; i++) step(1'b0, 12'h000, 1'b1);
`ifdef SHIFTER_FEEDER_TIMEOUT_EN
    chk("timeout_writes", wr_seen, 32'd2);
    chk("timeout_stall",  {31'd0, stall}, 32'd1);
`else
    chk("timeout_writes", wr_seen, 32'd1);
    chk("timeout_stall",  {31'd0, stall}, 32'd0);
`endif

    // Randomized traffic.
    apply_reset(1);
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
